// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling-layer engine.
// Imported by the reduction datapath and the layer walker.
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } pool_state_e;

  // Right shift that divides a window sum by WIN*WIN.
  function automatic int avg_shift(input int win);
    return 2 * $clog2(win);
  endfunction

endpackage

// File: rtl/pool_reduce.sv
// Window reduction datapath: running signed max and running sum.
// A tap with i_clear set restarts the window with that pixel.
module pool_reduce
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int WIN    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_tap,
  input  logic                     i_clear,
  input  pool_mode_e               i_mode,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_result
);

  localparam int SH = avg_shift(WIN);
  localparam int SW = DATA_W + SH;

  logic signed [DATA_W-1:0] r_max;
  logic signed [SW-1:0]     r_sum;
  logic signed [SW-1:0]     w_ext;

  assign w_ext = {{SH{i_data[DATA_W-1]}}, i_data};

  // Strict compare keeps the earlier pixel on ties.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_max <= '0;
      r_sum <= '0;
    end else if (i_tap) begin
      if (i_clear) begin
        r_max <= i_data;
        r_sum <= w_ext;
      end else begin
        if (i_data > r_max) r_max <= i_data;
        r_sum <= r_sum + w_ext;
      end
    end
  end

  assign o_result = (i_mode == POOL_AVG) ?
                    DATA_W'(r_sum >>> SH) : r_max;

endmodule

// File: rtl/pool_layer_engine.sv
// Pooling-layer engine: walks channels and windows of a feature map,
// reduces each window and writes the pooled map over one memory port.
module pool_layer_engine
  import pool_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int WIN    = 2,
  parameter int SIZE_W = 6,
  parameter int CH_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [SIZE_W-1:0] cfg_size,
  input  logic [CH_W-1:0]   cfg_channels,
  input  logic              cfg_mode,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LW = $clog2(WIN);

  pool_state_e r_state, w_next;
  pool_mode_e  r_mode;

  logic [ADDR_W-1:0] r_out_base;
  logic [ADDR_W-1:0] r_chan_base;
  logic [ADDR_W-1:0] r_nn;
  logic [ADDR_W-1:0] r_k;
  logic [SIZE_W-1:0] r_n;
  logic [SIZE_W-1:0] r_m;
  logic [SIZE_W-1:0] r_wy;
  logic [SIZE_W-1:0] r_wx;
  logic [CH_W-1:0]   r_chn;
  logic [CH_W-1:0]   r_c;
  logic [LW-1:0]     r_dy;
  logic [LW-1:0]     r_dx;

  logic w_degen;
  logic w_tap;
  logic w_first;
  logic w_wr_ack;
  logic w_last_tap;
  logic w_last_col;
  logic w_last_row;
  logic w_last_ch;
  logic w_last_win;

  logic [ADDR_W-1:0]        w_row;
  logic [ADDR_W-1:0]        w_col;
  logic [ADDR_W-1:0]        w_rd_addr;
  logic signed [DATA_W-1:0] w_result;

  assign w_degen = (cfg_size < SIZE_W'(WIN)) ||
                   (cfg_channels == '0);

  assign w_tap    = (r_state == RD) && mem_ack;
  assign w_wr_ack = (r_state == WR) && mem_ack;
  assign w_first  = (r_dx == '0) && (r_dy == '0);

  assign w_last_tap = (&r_dx) && (&r_dy);
  assign w_last_col = (r_wx == r_m - SIZE_W'(1));
  assign w_last_row = (r_wy == r_m - SIZE_W'(1));
  assign w_last_ch  = (r_c == r_chn - CH_W'(1));
  assign w_last_win = w_last_col && w_last_row && w_last_ch;

  // {wy,dy} and {wx,dx} are the pixel row/column since WIN is 2^LW.
  assign w_row     = ADDR_W'({r_wy, r_dy});
  assign w_col     = ADDR_W'({r_wx, r_dx});
  assign w_rd_addr = r_chan_base + w_row * ADDR_W'(r_n) + w_col;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = w_degen ? DONE : RD;
      RD:   if (mem_ack && w_last_tap) w_next = WR;
      WR:   if (mem_ack) w_next = w_last_win ? DONE : RD;
      DONE: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (r_state)
      IDLE: busy = 1'b0;
      RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = w_rd_addr;
      end
      WR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_out_base + r_k;
        mem_wdata = w_result;
      end
      DONE: done = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= POOL_MAX;
      r_out_base  <= '0;
      r_chan_base <= '0;
      r_nn        <= '0;
      r_k         <= '0;
      r_n         <= '0;
      r_m         <= '0;
      r_wy        <= '0;
      r_wx        <= '0;
      r_chn       <= '0;
      r_c         <= '0;
      r_dy        <= '0;
      r_dx        <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_mode      <= pool_mode_e'(cfg_mode);
        r_out_base  <= cfg_out_base;
        r_chan_base <= cfg_in_base;
        r_nn        <= ADDR_W'(cfg_size) * ADDR_W'(cfg_size);
        r_n         <= cfg_size;
        r_m         <= cfg_size >> LW;
        r_chn       <= cfg_channels;
        r_k         <= '0;
        r_wy        <= '0;
        r_wx        <= '0;
        r_c         <= '0;
        r_dy        <= '0;
        r_dx        <= '0;
      end
      if (w_tap) begin
        {r_dy, r_dx} <= {r_dy, r_dx} + (2*LW)'(1);
      end
      if (w_wr_ack) begin
        r_k <= r_k + ADDR_W'(1);
        if (w_last_col) begin
          r_wx <= '0;
          if (w_last_row) begin
            r_wy        <= '0;
            r_c         <= r_c + CH_W'(1);
            r_chan_base <= r_chan_base + r_nn;
          end else begin
            r_wy <= r_wy + SIZE_W'(1);
          end
        end else begin
          r_wx <= r_wx + SIZE_W'(1);
        end
      end
    end
  end

  pool_reduce #(
    .DATA_W (DATA_W),
    .WIN    (WIN)
  ) u_reduce (
    .clk      (clk),
    .reset    (reset),
    .i_tap    (w_tap),
    .i_clear  (w_first),
    .i_mode   (r_mode),
    .i_data   (mem_rdata),
    .o_result (w_result)
  );

endmodule

// File: tb/tb_pool_layer_engine.sv
// Directed bench for pool_layer_engine: WIN=2 and WIN=4 instances
// with memory models, write logging and handshake-stability checks.
module tb_pool_layer_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start4 = 1'b0;
  logic [15:0] cfg_in_base = '0;
  logic [15:0] cfg_out_base = '0;
  logic [5:0]  cfg_size = '0;
  logic [7:0]  cfg_channels = '0;
  logic        cfg_mode = 1'b0;

  logic busy, done, mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic busy4, done4, req4, we4, ack4;
  logic [15:0] addr4, wdata4, rdata4;

  logic signed [15:0] mem [0:1023];
  logic signed [15:0] mem4 [0:255];
  logic [15:0]        wr_addr [0:127];
  logic signed [15:0] wr_data [0:127];
  logic [15:0]        w4_addr [0:15];
  logic signed [15:0] w4_data [0:15];
  bit rd_seen [0:1023];

  int nw = 0;
  int nw4 = 0;
  int nreq = 0;
  int stab_err = 0;
  int wcnt = 0;
  bit rand_wait = 1'b0;
  bit hold = 1'b0;
  logic [15:0] h_addr, h_wd;
  logic        h_we;

  int checks = 0;
  int errors = 0;
  int b, cyc, n0, bad, good;
  int exp1 [4] = '{5, 7, 13, 15};
  int exp4 [4] = '{7, 7, 100, 7};

  always #5 clk = ~clk;

  pool_layer_engine #(
    .DATA_W(16), .ADDR_W(16), .WIN(2), .SIZE_W(6), .CH_W(8)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_in_base  (cfg_in_base),
    .cfg_out_base (cfg_out_base),
    .cfg_size     (cfg_size),
    .cfg_channels (cfg_channels),
    .cfg_mode     (cfg_mode),
    .busy         (busy),
    .done         (done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  pool_layer_engine #(
    .DATA_W(16), .ADDR_W(16), .WIN(4), .SIZE_W(6), .CH_W(8)
  ) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .start        (start4),
    .cfg_in_base  (cfg_in_base),
    .cfg_out_base (cfg_out_base),
    .cfg_size     (cfg_size),
    .cfg_channels (cfg_channels),
    .cfg_mode     (cfg_mode),
    .busy         (busy4),
    .done         (done4),
    .mem_req      (req4),
    .mem_we       (we4),
    .mem_addr     (addr4),
    .mem_wdata    (wdata4),
    .mem_ack      (ack4),
    .mem_rdata    (rdata4)
  );

  assign mem_rdata = mem[mem_addr[9:0]];
  assign mem_ack   = mem_req && (wcnt == 0);
  assign rdata4    = mem4[addr4[7:0]];
  assign ack4      = req4;

  always @(posedge clk) begin
    hold   <= mem_req && !mem_ack && !reset;
    h_addr <= mem_addr;
    h_we   <= mem_we;
    h_wd   <= mem_wdata;
    if (mem_req && !reset) begin
      nreq <= nreq + 1;
      if (hold && (mem_addr !== h_addr || mem_we !== h_we ||
                   mem_wdata !== h_wd))
        stab_err <= stab_err + 1;
      if (mem_ack) begin
        wcnt <= rand_wait ? int'($urandom_range(0, 3)) : 0;
        if (mem_we) begin
          wr_addr[nw[6:0]] <= mem_addr;
          wr_data[nw[6:0]] <= mem_wdata;
          nw <= nw + 1;
        end else begin
          rd_seen[mem_addr[9:0]] <= 1'b1;
        end
      end else begin
        wcnt <= wcnt - 1;
      end
    end
    if (req4 && ack4 && we4 && !reset) begin
      w4_addr[nw4[3:0]] <= addr4;
      w4_data[nw4[3:0]] <= wdata4;
      nw4 <= nw4 + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_layer(output int c);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run_layer4(output int c);
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    c = 1;
    while (!done4 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("done4_seen", done4, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 256; i++) mem4[i] = 16'sd7;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_req4", req4, 0);
    reset = 1'b0;
    @(negedge clk);

    // Max pooling, 4x4 ramp, zero wait states.
    for (int i = 0; i < 16; i++) mem[100+i] = 16'(i);
    cfg_in_base = 16'd100;
    cfg_out_base = 16'd200;
    cfg_size = 6'd4;
    cfg_channels = 8'd1;
    cfg_mode = 1'b0;
    b = nw;
    run_layer(cyc);
    chk("t1_latency", cyc, 21);
    chk("t1_nwr", nw - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", wr_addr[b+i], 200 + i);
      chk("t1_data", wr_data[b+i], exp1[i]);
    end
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);

    // Average with negative pixels, floor rounding.
    mem[10] = -16'sd1;
    mem[11] = -16'sd2;
    mem[12] = -16'sd3;
    mem[13] = 16'sd4;
    cfg_in_base = 16'd10;
    cfg_out_base = 16'd20;
    cfg_size = 6'd2;
    cfg_mode = 1'b1;
    b = nw;
    run_layer(cyc);
    chk("t2a_latency", cyc, 6);
    chk("t2a_addr", wr_addr[b], 20);
    chk("t2a_data", wr_data[b], -1);
    mem[10] = -16'sd5;
    mem[11] = -16'sd5;
    mem[12] = -16'sd5;
    mem[13] = -16'sd6;
    b = nw;
    run_layer(cyc);
    chk("t2b_data", wr_data[b], -6);
    cfg_mode = 1'b0;
    b = nw;
    run_layer(cyc);
    chk("t2c_max_neg", wr_data[b], -5);

    // Odd edge, three channels, random ack delays, start while busy.
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          mem[300 + c*25 + y*5 + x] = 16'(c*100 + y*10 + x - 50);
    cfg_in_base = 16'd300;
    cfg_out_base = 16'd500;
    cfg_size = 6'd5;
    cfg_channels = 8'd3;
    cfg_mode = 1'b0;
    rand_wait = 1'b1;
    b = nw;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (nw - b < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    cfg_mode = 1'b1;
    cfg_out_base = 16'd900;
    cfg_size = 6'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t3_busy_hold", busy, 1);
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_done", done, 1);
    chk("t3_nwr", nw - b, 12);
    for (int k = 0; k < 12; k++) begin
      chk("t3_addr", wr_addr[b+k], 500 + k);
      chk("t3_data", wr_data[b+k],
          (k/4)*100 + (2*((k%4)/2)+1)*10 + 2*(k%2) + 1 - 50);
    end
    bad = 0;
    good = 0;
    for (int c = 0; c < 3; c++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          if (rd_seen[300 + c*25 + y*5 + x]) begin
            if (y == 4 || x == 4) bad++;
            else good++;
          end
    chk("t3_trailing_unread", bad, 0);
    chk("t3_window_reads", good, 48);
    chk("t3_stable", stab_err, 0);
    rand_wait = 1'b0;
    repeat (6) @(negedge clk);

    // Degenerate configurations: N < WIN, then C = 0.
    cfg_size = 6'd1;
    cfg_channels = 8'd1;
    n0 = nreq;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dg1_done", done, 1);
    chk("dg1_busy", busy, 0);
    @(negedge clk);
    chk("dg1_pulse", done, 0);
    chk("dg1_noreq", nreq - n0, 0);
    cfg_size = 6'd4;
    cfg_channels = 8'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dg0_done", done, 1);
    chk("dg0_busy", busy, 0);
    @(negedge clk);
    chk("dg0_noreq", nreq - n0, 0);

    // Reset during the third window's reads, then a clean layer.
    cfg_in_base = 16'd100;
    cfg_out_base = 16'd250;
    cfg_channels = 8'd1;
    cfg_mode = 1'b0;
    b = nw;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!(nw - b == 2 && mem_req && !mem_we) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("rs_reached", (nw - b == 2) && mem_req && !mem_we, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_req", mem_req, 0);
    chk("rs_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_no_write", nw - b, 2);
    b = nw;
    run_layer(cyc);
    chk("rs_latency", cyc, 21);
    chk("rs_nwr", nw - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("rs_addr", wr_addr[b+i], 250 + i);
      chk("rs_data", wr_data[b+i], exp1[i]);
    end

    // WIN=4 instance: flat average, then max with one hot pixel.
    cfg_in_base = 16'd0;
    cfg_out_base = 16'd100;
    cfg_size = 6'd8;
    cfg_channels = 8'd1;
    cfg_mode = 1'b1;
    b = nw4;
    run_layer4(cyc);
    chk("w4a_latency", cyc, 69);
    chk("w4a_nwr", nw4 - b, 4);
    for (int i = 0; i < 4; i++) begin
      chk("w4a_addr", w4_addr[b+i], 100 + i);
      chk("w4a_data", w4_data[b+i], 7);
    end
    mem4[42] = 16'sd100;
    cfg_mode = 1'b0;
    b = nw4;
    run_layer4(cyc);
    chk("w4b_nwr", nw4 - b, 4);
    for (int i = 0; i < 4; i++)
      chk("w4b_data", w4_data[b+i], exp4[i]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_layer_engine.md
Name: pool_layer_engine

Overview:
Parametrised pooling-layer engine for the CNN accelerator. Replaces the hard-coded 2x2 pooling loop in the top-level layer sequencer with a self-contained block. On a start pulse it walks every channel and every pooling window of a feature map in memory, reduces each window (max or average), and writes the pooled map back through a single request/acknowledge memory port. The top-level sequencer only supplies the layer configuration and waits for done.

Parameters:
DATA_W, 16, signed pixel width
ADDR_W, 16, memory word-address width
WIN, 2, window edge and stride; must be a power of 2, at least 2
SIZE_W, 6, width of the feature-map edge field (max edge 63)
CH_W, 8, width of the channel-count field

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle launch pulse; sampled only in IDLE
cfg_in_base  in  ADDR_W  address of first input pixel
cfg_out_base  in  ADDR_W  address of first output pixel
cfg_size  in  SIZE_W  input map edge N
cfg_channels  in  CH_W  number of channels C
cfg_mode  in  1  0 = max, 1 = average
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the layer is complete
mem_req  out  1  memory transaction request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  transaction address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  transaction accepted; completes in any cycle where mem_req && mem_ack
mem_rdata  in  DATA_W  read data, valid in the read's completing cycle

Behaviour:
- Reset values: busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; FSM returns to IDLE.
- Reset mid-operation aborts immediately. mem_req drops in the next cycle and no further writes are issued.
- Accepted start latches all cfg_* inputs. cfg changes while busy have no effect.
- start while busy is ignored.
- Memory layout: channel-major, then row-major.
  - Input pixel (c,y,x) is at in_base + c*N*N + y*N + x.
  - Output pixel is at out_base + k, where k counts up from 0 in channel/row/column order.
  - Output edge M = floor(N/WIN). Trailing rows and columns beyond M*WIN are never read.
- Degenerate configuration (N < WIN or C = 0): done pulses the cycle after start, busy stays 0, and no memory traffic occurs.
- FSM states:
  - IDLE: on start, go to RD.
  - RD: issue WIN*WIN reads for the current window in row-major order (dy outer, dx inner). Each read completes on its ack. After the last read, go to WR.
  - WR: issue one write of the reduced value. On ack, advance wx; on wrap, advance wy; on wrap, advance channel. After the last window of the last channel, go to DONE; otherwise go to RD.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable while mem_req=1 and mem_ack=0.
  - mem_ack may arrive in the same cycle as mem_req (zero wait states).
  - The next request is asserted in the cycle after completion, so each transaction occupies at least 1 cycle.
  - Minimum latency is C*M*M*(WIN*WIN+1) cycles from start to done, plus 1 for the done cycle.
- Reduction:
  - Max mode uses a signed compare. The first read initialises the accumulator. On equal values the earlier value is kept.
  - Average mode uses a signed sum of width DATA_W + 2*log2(WIN), with no overflow possible. The result is sum >>> 2*log2(WIN) (arithmetic shift, floor toward negative infinity), truncated to DATA_W.
- Counters: channel (CH_W bits), wy/wx (SIZE_W bits), tap dy/dx (log2(WIN) bits each), out index k (ADDR_W bits). Addresses wrap modulo 2^ADDR_W.

Decomposition:
- Package pool_pkg holds:
  - pool_mode_e (POOL_MAX, POOL_AVG)
  - pool_state_e (IDLE, RD, WR, DONE)
  - the helper function computing the average shift amount from WIN
- One sub-module, pool_reduce: accumulator with clear / accumulate-tap / result ports, parametrised by DATA_W and WIN, holding both the max and average datapaths.

Test Plan:
- Max, zero wait: N=4, C=1, mode=0, zero-wait ack, input 0..15 at in_base 100, out_base 200 → writes 5,7,13,15 to 200..203; done after 21 cycles.
- Average with negatives: N=2, C=1, window {-1,-2,-3,4} → writes -1 (sum -2 >>> 2); window {-5,-5,-5,-6} → -6.
- Odd edge, multi-channel, wait states: N=5, C=3, random ack delays of 0–3 cycles → 12 writes to out_base+0..11; pixels in row 4 and column 4 are never read; addresses and data are stable during waits.
- Busy and degenerate starts: start pulse mid-layer → ignored, output unchanged; start with C=0 or N=1 → done the next cycle, no mem_req.
- Reset mid-operation: reset during the 3rd window's RD → mem_req=0 the next cycle, busy=0; a new start then runs a correct full layer.
- WIN=4 build: N=8, C=1, mode=1, all pixels 7 → four writes of 7; mode=0 with a single pixel of 100 in window 2 → that output is 100.
